// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: decodes 16-bit instruction words into stage-1 mux selects and carries
// valid, write-enable and destination down a STAGES-deep control pipeline.
//
// Parameters:
//   STAGES  pipeline depth (2..8)
//   CNT_W   width of the retire counter
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   op_valid  op_in holds an instruction offered for acceptance
//   op_in     instruction word
//   stall     freeze every stage this cycle
//   flush     kill stages 1..STAGES-1 (taken branch); wins over stall
//   op_ready  offered instruction is accepted this cycle when op_valid is high
//   ctl_d     stage-1 mux selects {s7,s6,s5,s4,s3,s2,s1}, zero when stage 1 is empty
//   v_d       stage 1 valid
//   we_w      last-stage register write enable
//   wdst_w    last-stage destination register
//   retired   count of valid instructions leaving the last stage
//
// Optional feature: define CTRL_HAZARD_EN to hold off an instruction that reads the
// destination of a load sitting in stage 1 (one bubble is inserted).

module ctrl_pipeline #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [15:0]      op_in,
    input  logic             stall,
    input  logic             flush,
    output logic             op_ready,
    output logic [6:0]       ctl_d,
    output logic             v_d,
    output logic             we_w,
    output logic [2:0]       wdst_w,
    output logic [CNT_W-1:0] retired
);

    // Index 0 is stage 1, index STAGES-1 is the last stage.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] we_q;
    logic [2:0]        dst_q [STAGES];
    logic [6:0]        ctl_q;
    logic [CNT_W-1:0]  retired_q;

    logic [6:0] dec_ctl;
    logic       dec_we;
    logic       hazard;
    logic       accept;
    logic       retire;

    // Low nibble of the instruction carries no control information.
    logic unused_op_bits;
    assign unused_op_bits = ^op_in[3:0];

    // Decode; bit 0 of dec_ctl is s1, bit 6 is s7.
    always_comb begin
        dec_ctl = 7'b0000000;
        dec_we  = 1'b0;
        unique case (op_in[15:14])
            2'b00: begin
                dec_ctl = 7'b0010100;
                dec_we  = 1'b1;
            end
            2'b01: begin
                dec_ctl = 7'b0100100;
                dec_we  = 1'b1;
            end
            2'b10: begin
                unique case (op_in[13:11])
                    3'b000, 3'b001, 3'b010, 3'b011: dec_ctl = 7'b0000100;
                    3'b101:                         dec_ctl = 7'b0000101;
                    3'b110:                         dec_ctl = 7'b1000111;
                    default:                        dec_ctl = 7'b0000111;
                endcase
                dec_we = (op_in[13:11] == 3'b000) || (op_in[13:11] == 3'b001) ||
                         (op_in[13:11] == 3'b010) || (op_in[13:11] == 3'b110);
            end
            default: begin
                dec_ctl = (op_in[7:4] == 4'b1100) ? 7'b0011000 : 7'b0000000;
                dec_we  = !((op_in[7:4] == 4'd5)  || (op_in[7:4] == 4'd7) ||
                            (op_in[7:4] == 4'd13) || (op_in[7:4] == 4'd14) ||
                            (op_in[7:4] == 4'd15));
            end
        endcase
    end

`ifdef CTRL_HAZARD_EN
    logic ld_q;

    // A load in stage 1 whose destination is a source of the offered instruction.
    assign hazard = vld_q[0] && ld_q && op_valid &&
                    ((dst_q[0] == op_in[13:11]) || (dst_q[0] == op_in[10:8]));
`else
    assign hazard = 1'b0;
`endif

    assign op_ready = rst_n && !stall && !flush && !hazard;
    assign accept   = op_valid && op_ready;
    // Flush lets the last stage leave even when stall is also asserted.
    assign retire   = vld_q[STAGES-1] && (flush || !stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            we_q      <= '0;
            ctl_q     <= '0;
            retired_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dst_q[i] <= 3'b000;
            end
`ifdef CTRL_HAZARD_EN
            ld_q      <= 1'b0;
`endif
        end else begin
            if (flush) begin
                vld_q <= '0;
            end else if (!stall) begin
                vld_q <= {vld_q[STAGES-2:0], accept};
            end
            if (!stall) begin
                ctl_q    <= dec_ctl;
                we_q     <= {we_q[STAGES-2:0], dec_we};
                dst_q[0] <= op_in[10:8];
                for (int i = 1; i < STAGES; i++) begin
                    dst_q[i] <= dst_q[i-1];
                end
`ifdef CTRL_HAZARD_EN
                ld_q     <= (op_in[15:14] == 2'b00);
`endif
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign v_d     = vld_q[0];
    assign ctl_d   = vld_q[0] ? ctl_q : 7'b0000000;
    assign we_w    = vld_q[STAGES-1] && we_q[STAGES-1];
    assign wdst_w  = dst_q[STAGES-1];
    assign retired = retired_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline with STAGES=3, CNT_W=16.
module tb_ctrl_pipeline;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [15:0] op_in;
    logic        stall;
    logic        flush;
    logic        op_ready;
    logic [6:0]  ctl_d;
    logic        v_d;
    logic        we_w;
    logic [2:0]  wdst_w;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    ctrl_pipeline #(
        .STAGES (3),
        .CNT_W  (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_in    (op_in),
        .stall    (stall),
        .flush    (flush),
        .op_ready (op_ready),
        .ctl_d    (ctl_d),
        .v_d      (v_d),
        .we_w     (we_w),
        .wdst_w   (wdst_w),
        .retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_in    = 16'h0000;
        stall    = 1'b0;
        flush    = 1'b0;
        #2;
        check("rst_vd",    v_d,      0);
        check("rst_ctl",   ctl_d,    0);
        check("rst_we",    we_w,     0);
        check("rst_wdst",  wdst_w,   0);
        check("rst_ret",   retired,  0);
        check("rst_ready", op_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", op_ready, 1);

        // Single 0xC0C0 through the pipe.
        op_valid = 1'b1;
        op_in    = 16'hC0C0;
        tick();
        op_valid = 1'b0;
        check("c0c0_vd",  v_d,   1);
        check("c0c0_ctl", ctl_d, 7'b0011000);
        check("c0c0_ret", retired, 0);
        tick();
        tick();
        check("c0c0_we",   we_w,   1);
        check("c0c0_wdst", wdst_w, 0);
        tick();
        check("c0c0_ret1", retired, 1);
        check("c0c0_we0",  we_w,    0);

        // Back-to-back B000, A800, 4700.
        op_valid = 1'b1;
        op_in    = 16'hB000;
        tick();
        check("b000_ctl", ctl_d, 7'b1000111);
        op_in = 16'hA800;
        tick();
        check("a800_ctl", ctl_d, 7'b0000101);
        op_in = 16'h4700;
        tick();
        op_valid = 1'b0;
        check("4700_ctl",  ctl_d,  7'b0100100);
        check("b000_we",   we_w,   1);
        check("b000_wdst", wdst_w, 0);
        tick();
        check("a800_we",  we_w,    0);
        check("seq_ret2", retired, 2);
        tick();
        check("4700_we",   we_w,    1);
        check("4700_wdst", wdst_w,  7);
        check("seq_ret3",  retired, 3);
        tick();
        check("seq_ret4", retired, 4);
        check("seq_vd0",  v_d,     0);

        // Class 11 with op[7:4]=5: no selects, no write.
        op_valid = 1'b1;
        op_in    = 16'hC050;
        tick();
        op_valid = 1'b0;
        check("c050_vd",  v_d,   1);
        check("c050_ctl", ctl_d, 0);
        tick();
        tick();
        check("c050_we", we_w, 0);
        tick();
        check("c050_ret", retired, 5);

        // Four ops with a two-cycle stall while the first is in the last stage.
        op_valid = 1'b1;
        op_in    = 16'h0100;
        tick();
        op_in = 16'h4200;
        tick();
        op_in = 16'h8000;
        tick();
        check("pre_stall_wdst", wdst_w, 1);
        stall = 1'b1;
        op_in = 16'hC0C0;
        #1;
        check("stall_ready", op_ready, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_vd",   v_d,     1);
            check("stall_ctl",  ctl_d,   7'b0000100);
            check("stall_we",   we_w,    1);
            check("stall_wdst", wdst_w,  1);
            check("stall_ret",  retired, 5);
        end
        stall = 1'b0;
        tick();
        op_valid = 1'b0;
        check("post_stall_ctl", ctl_d,   7'b0011000);
        check("post_stall_r6",  retired, 6);
        tick();
        check("post_stall_r7", retired, 7);
        tick();
        check("post_stall_r8", retired, 8);
        tick();
        check("post_stall_r9", retired, 9);

        // Flush together with stall, three in flight.
        op_valid = 1'b1;
        op_in    = 16'hC000;
        tick();
        op_in = 16'h0100;
        tick();
        op_in = 16'h4200;
        tick();
        flush = 1'b1;
        stall = 1'b1;
        op_in = 16'h8000;
        #1;
        check("flush_ready", op_ready, 0);
        tick();
        check("flush_vd",  v_d,     0);
        check("flush_ctl", ctl_d,   0);
        check("flush_we",  we_w,    0);
        check("flush_ret", retired, 10);
        flush    = 1'b0;
        stall    = 1'b0;
        op_valid = 1'b0;
        tick();
        tick();
        tick();
        check("flush_ret_hold", retired, 10);
        check("flush_we_hold",  we_w,    0);

        // Load to r3 followed by a reader of r3.
        op_valid = 1'b1;
        op_in    = 16'h0300;
        tick();
        op_in = 16'hC3C0;
        #1;
`ifdef CTRL_HAZARD_EN
        check("hz_ready", op_ready, 0);
        tick();
        check("hz_bubble", v_d, 0);
        tick();
        check("hz_vd",  v_d,   1);
        check("hz_ctl", ctl_d, 7'b0011000);
`else
        check("nohz_ready", op_ready, 1);
        tick();
        check("nohz_vd",  v_d,   1);
        check("nohz_ctl", ctl_d, 7'b0011000);
`endif
        op_valid = 1'b0;
        repeat (4) tick();
        check("hz_ret", retired, 12);

        // Asynchronous reset with work in flight.
        op_valid = 1'b1;
        op_in    = 16'hC5C0;
        tick();
        op_in = 16'h0100;
        tick();
        op_in = 16'h0200;
        tick();
        op_valid = 1'b0;
        check("mid_we",   we_w,   1);
        check("mid_wdst", wdst_w, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vd",    v_d,      0);
        check("arst_ctl",   ctl_d,    0);
        check("arst_we",    we_w,     0);
        check("arst_wdst",  wdst_w,   0);
        check("arst_ret",   retired,  0);
        check("arst_ready", op_ready, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("arst_ready1", op_ready, 1);

        // Retire counter wrap.
        op_valid = 1'b1;
        op_in    = 16'h0700;
        repeat (65535) tick();
        op_valid = 1'b0;
        repeat (3) tick();
        check("wrap_ffff", retired, 16'hFFFF);
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        repeat (3) tick();
        check("wrap_zero", retired, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 SHALL provide parameter STAGES, default 3, meaning control pipeline depth, legal range 2..8.
REQ-002 SHALL provide parameter CNT_W, default 16, meaning retire-counter width.
REQ-003 SHALL provide port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL provide port op_valid  input  1  meaning op_in holds an instruction offered for acceptance.
REQ-006 SHALL provide port op_in  input  16  meaning the instruction word.
REQ-007 SHALL provide port stall  input  1  meaning freeze all stages this cycle.
REQ-008 SHALL provide port flush  input  1  meaning kill stages 1..STAGES-1 (taken branch).
REQ-009 SHALL provide port op_ready  output  1  meaning the offered instruction is accepted this cycle when op_valid is also high.
REQ-010 SHALL provide port ctl_d  output  7  meaning the stage-1 mux-select bus {s7,s6,s5,s4,s3,s2,s1}.
REQ-011 SHALL provide port v_d  output  1  meaning stage 1 is valid.
REQ-012 SHALL provide port we_w  output  1  meaning register write enable of the last stage.
REQ-013 SHALL provide port wdst_w  output  3  meaning destination register of the last stage (op[10:8]).
REQ-014 SHALL provide port retired  output  CNT_W  meaning count of valid instructions leaving the last stage.

Function
REQ-015 SHALL decode op[15:14]=11: s4=s5=1 when op[7:4]=1100, else all switches 0; we=0 for op[7:4] in {5,7,13,14,15}, else 1.
REQ-016 SHALL decode op[15:14]=10 by op[13:11]: 000..011 -> s3; 101 -> s1,s3; 110 -> s1,s2,s3,s7; 100/111 -> s1,s2,s3; we=1 for 000,001,010,110, else 0.
REQ-017 SHALL decode op[15:14]=00 -> s3,s5, we=1; op[15:14]=01 -> s3,s6, we=1.
REQ-018 SHALL register decode into stage 1 one cycle after acceptance; each stage advances one per cycle; we_w appears STAGES cycles after acceptance.
REQ-019 SHALL drive ctl_d=0 when v_d=0 and we_w=0 when the last stage is invalid.
REQ-020 SHALL accept when op_valid & op_ready; an unaccepted cycle inserts a bubble (valid=0) into stage 1.
REQ-021 SHALL, on stall=1 without flush, hold every stage and the counter, and drive op_ready=0.
REQ-022 SHALL, on flush=1, clear valid of stages 1..STAGES-1 at the next edge, let the last stage retire, drive op_ready=0; flush has priority over stall.
REQ-023 SHALL increment retired when the last stage is valid and not stalled, wrapping from all-ones to 0.

Reset
REQ-024 SHALL, while rst_n=0, immediately clear all valid bits, ctl_d, we_w, wdst_w, retired to 0 and drive op_ready=0; in-flight instructions are discarded.
REQ-025 SHALL drive op_ready=1 (absent stall/flush/hazard) in the first cycle after rst_n rises.

Configuration
REQ-026 SHALL, with macro CTRL_HAZARD_EN defined, drive op_ready=0 when stage 1 holds a valid load (op[15:14]=00) whose op[10:8] equals op_in[13:11] or op_in[10:8] of a valid offered instruction, inserting exactly one bubble.
REQ-027 SHALL, without CTRL_HAZARD_EN, contain no hazard logic: op_ready = ~stall & ~flush.

Verification
REQ-028 SHALL cover: reset, accept op=0xC0C0 at cycle 0 -> ctl_d=0011000, v_d=1 at cycle 1; we_w=1, wdst_w=0 at cycle 3 (STAGES=3).
REQ-029 SHALL cover: op=0xB000 (10,110) -> ctl_d=1000111, we_w=1; op=0xA800 (10,101) -> ctl_d=0000101, we_w=0.
REQ-030 SHALL cover: 4 back-to-back ops, stall high 2 cycles mid-stream -> outputs frozen, retired reaches 4 two cycles late.
REQ-031 SHALL cover: flush together with stall while 3 in flight -> only last-stage op retires, retired +1, stages 1..2 invalid.
REQ-032 SHALL cover: with CTRL_HAZARD_EN, load 0x0300 then 0xC3xx -> op_ready=0 one cycle, one bubble; without macro -> no bubble.
REQ-033 SHALL cover: rst_n low mid-stream -> all outputs 0 asynchronously; retired wraps 0xFFFF -> 0 with CNT_W=16.
